sync_fifo_ctrl: RTL



---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_ptr.sv | 27 ++
 rtl/sync_fifo_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for the single-clock synchronous FIFO: data width,
// RAM geometry and default flag thresholds.
package fifo_pkg;

  localparam int DATA_WIDTH    = 8;
  localparam int ADDR_WIDTH    = 9;
  localparam int DEPTH         = 512;
  localparam int AFULL_THRESH  = 480;
  localparam int AEMPTY_THRESH = 32;

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer: W-bit binary register that advances by one when enabled.
// The MSB is the wrap bit; the counter wraps naturally at 2**W.
module fifo_ptr #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  // Pointer register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr <= {W{1'b0}};
    end else if (i_inc) begin
      r_ptr <= r_ptr + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_ptr <= r_ptr;
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Pointer, flag, count and sticky-error controller for the synchronous FIFO;
// drives the write/read ports of the downstream dual-port RAM.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH    = fifo_pkg::ADDR_WIDTH,
  parameter int DEPTH         = fifo_pkg::DEPTH,
  parameter int AFULL_THRESH  = fifo_pkg::AFULL_THRESH,
  parameter int AEMPTY_THRESH = fifo_pkg::AEMPTY_THRESH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic                  rd_en,
  output logic                  ram_w_enable,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic                  ram_r_enable,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   data_count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0] AFULL_C  = (ADDR_WIDTH+1)'(AFULL_THRESH);
  localparam logic [ADDR_WIDTH:0] AEMPTY_C = (ADDR_WIDTH+1)'(AEMPTY_THRESH);
  localparam logic [ADDR_WIDTH:0] ONE_C    = (ADDR_WIDTH+1)'(1);

  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_depth_check
    $error("DEPTH must equal 2**ADDR_WIDTH");
  end

  logic [ADDR_WIDTH:0] w_wptr;
  logic [ADDR_WIDTH:0] w_rptr;
  logic                w_full;
  logic                w_empty;
  logic                w_wr_acc;
  logic                w_rd_acc;

  logic [ADDR_WIDTH:0] r_count;
  logic                r_rd_valid;
  logic                r_overflow;
  logic                r_underflow;

  fifo_ptr #(.W(ADDR_WIDTH+1)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_wr_acc),
    .o_ptr (w_wptr)
  );

  fifo_ptr #(.W(ADDR_WIDTH+1)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_rd_acc),
    .o_ptr (w_rptr)
  );

  assign w_empty = (w_wptr == w_rptr);
  assign w_full  = (w_wptr[ADDR_WIDTH] != w_rptr[ADDR_WIDTH]) &&
                   (w_wptr[ADDR_WIDTH-1:0] == w_rptr[ADDR_WIDTH-1:0]);

  // Gating with rst_n keeps the RAM enables low during reset cycles
  assign w_wr_acc = rst_n & wr_en & ~w_full;
  assign w_rd_acc = rst_n & rd_en & ~w_empty;

  // Occupancy counter: simultaneous accepted push and pop cancel out
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count <= {(ADDR_WIDTH+1){1'b0}};
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + ONE_C;
        2'b01:   r_count <= r_count - ONE_C;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read-data valid tracks the RAM's one-cycle registered read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= w_rd_acc;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= r_overflow  | (wr_en & w_full);
      r_underflow <= r_underflow | (rd_en & w_empty);
    end
  end

  assign ram_w_enable = w_wr_acc;
  assign ram_w_addr   = w_wptr[ADDR_WIDTH-1:0];
  assign ram_r_enable = w_rd_acc;
  assign ram_r_addr   = w_rptr[ADDR_WIDTH-1:0];
  assign rd_valid     = r_rd_valid;
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= AFULL_C);
  assign almost_empty = (r_count <= AEMPTY_C);
  assign data_count   = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
